// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare opcodes, exponent limit and IEEE-754 single
// classification helpers used by the compare datapath.
package fpu_pkg;

  typedef enum logic [1:0] {
    FCMP_EQ   = 2'b00,
    FCMP_LT   = 2'b01,
    FCMP_LE   = 2'b10,
    FCMP_RSVD = 2'b11
  } fcmp_op_e;

  localparam logic [7:0] EXP_MAX = 8'd255;

  // NaN: all-ones exponent with a non-zero mantissa (quiet or signalling).
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  // Zero of either sign.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational single-precision compare (feq/flt/fle).
// Optional feature macro: FCMP_NV_FLAG_EN drives the invalid flag; otherwise nv is 0.
module fcmp_core
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic        y,
  output logic        nv
);

  fcmp_op_e op_e;
  logic     any_nan;
  logic     both_zero;
  logic     eq;
  logic     lt;

  assign op_e      = fcmp_op_e'(op);
  assign any_nan   = is_nan(x1) || is_nan(x2);
  assign both_zero = is_zero(x1) && is_zero(x2);

  // Signed-magnitude ordering: mixed signs decided by sign, negatives reverse magnitude.
  always_comb begin
    lt = 1'b0;
    if (x1[31] != x2[31]) begin
      lt = x1[31];
    end else if (x1[31]) begin
      lt = (x1[30:0] > x2[30:0]);
    end else begin
      lt = (x1[30:0] < x2[30:0]);
    end
    if (any_nan || both_zero) begin
      lt = 1'b0;
    end
    eq = !any_nan && (both_zero || (x1 == x2));
  end

  // Opcode select; the reserved encoding always reports false.
  always_comb begin
    y = 1'b0;
    unique case (op_e)
      FCMP_EQ:   y = eq;
      FCMP_LT:   y = lt;
      FCMP_LE:   y = lt || eq;
      FCMP_RSVD: y = 1'b0;
      default:   y = 1'b0;
    endcase
  end

`ifdef FCMP_NV_FLAG_EN
  assign nv = any_nan;
`else
  assign nv = 1'b0;
`endif

endmodule

// File: rtl/fcmp_stage.sv
// Compare stage: fcmp_core followed by a 2-entry valid/ready result FIFO.
// Optional feature macro: FCMP_NV_FLAG_EN stores and drives nv; otherwise nv is tied to 0.
module fcmp_stage
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        y,
  output logic        nv
);

  logic       core_y;
  logic       core_nv;
  logic       push;
  logic       pop;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] y_mem_q, y_mem_d;

  fcmp_core u_core (
    .x1 (x1),
    .x2 (x2),
    .op (op),
    .y  (core_y),
    .nv (core_nv)
  );

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for occupancy, pointers and result storage.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    y_mem_d  = y_mem_q;
    if (push) begin
      y_mem_d[wr_ptr_q] = core_y;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous active-low reset that flushes the buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      y_mem_q  <= 2'b00;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      y_mem_q  <= y_mem_d;
    end
  end

  assign y = y_mem_q[rd_ptr_q];

`ifdef FCMP_NV_FLAG_EN
  logic [1:0] nv_mem_q, nv_mem_d;

  // Invalid-flag storage tracks the result entries slot for slot.
  always_comb begin
    nv_mem_d = nv_mem_q;
    if (push) begin
      nv_mem_d[wr_ptr_q] = core_nv;
    end
  end

  // Flag register, cleared with the rest of the buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      nv_mem_q <= 2'b00;
    end else begin
      nv_mem_q <= nv_mem_d;
    end
  end

  assign nv = nv_mem_q[rd_ptr_q];
`else
  // core_nv is constant 0 in this build, so no storage is needed.
  assign nv = core_nv;
`endif

endmodule
